io_dispatcher: RTL and testbench
================================

IO_DISPATCHER -- requirements
Module: io_dispatcher

Interface
REQ-001 Parameter INSTRUCTION_SIZE, default 3, opcode width.
REQ-002 Parameter REGISTER_SIZE, default 5, I/O pin-select width.
REQ-003 Parameter AUXILIAR_SIZE, default 44, auxiliary/delay operand width.
REQ-004 Parameter IO_OUTPUT_SIZE, default 8, read-result width.
REQ-005 Parameter FIFO_DEPTH, default 4, command buffer entries (power of two).
REQ-006 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-007 Host ports SHALL be: cmd_valid in 1; cmd_ready out 1; cmd_instruction in INSTRUCTION_SIZE; cmd_register in REGISTER_SIZE; cmd_auxiliar in AUXILIAR_SIZE.
REQ-008 Response ports SHALL be: rsp_valid out 1, one-cycle pulse; rsp_data out IO_OUTPUT_SIZE; rsp_error out 1.
REQ-009 Execution-unit ports SHALL be: io_instruction out INSTRUCTION_SIZE; io_register out REGISTER_SIZE; io_auxiliar out AUXILIAR_SIZE; io_valid_instruction out 1; io_busy in 1; io_valid in 1; io_result in IO_OUTPUT_SIZE.

Function
REQ-010 Command SHALL be pushed into the FIFO on the clk edge where cmd_valid && cmd_ready; cmd_ready = !fifo_full.
REQ-011 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND.
REQ-012 IDLE: fifo non-empty && !io_busy -> pop head into holding registers, go ISSUE; else stay.
REQ-013 ISSUE: io_valid_instruction = 1 for exactly this cycle; next state WAIT_BUSY.
REQ-014 WAIT_BUSY: io_busy = 1 -> WAIT_DONE; else stay.
REQ-015 WAIT_DONE: io_busy = 0 -> RESPOND; on that cycle, if opcode is 100, 101 or 110 and io_valid = 1, capture io_result into rsp_data; otherwise rsp_data <= 0.
REQ-016 io_valid SHALL be ignored for opcodes 000, 001, 010, 011, 111.
REQ-017 RESPOND: rsp_valid = 1 for one cycle, rsp_error = 0, then IDLE; there is no response backpressure.
REQ-018 io_instruction, io_register and io_auxiliar SHALL be driven from the holding registers and held stable from ISSUE until leaving WAIT_DONE.
REQ-019 Minimum latency from pop to rsp_valid SHALL be 4 cycles (ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND) when io_busy spans one cycle.
REQ-020 On an empty FIFO no pop SHALL occur; a push into an empty FIFO is poppable no earlier than the next cycle.
REQ-021 Push and pop in the same cycle SHALL be allowed when the FIFO is neither full nor empty; the count is unchanged.
REQ-022 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, with a log2(FIFO_DEPTH)+1-bit occupancy count.
REQ-023 A push into a full FIFO is not possible; commands are never dropped.

Reset
REQ-024 While rst is asserted: FSM = IDLE; FIFO empty; cmd_ready = 1; rsp_valid = 0; rsp_data = 0; rsp_error = 0; io_valid_instruction = 0; io_instruction/io_register/io_auxiliar = 0.
REQ-025 Reset asserted mid-operation SHALL discard in-flight and buffered commands without emitting a response.

Configuration
REQ-026 Macro IO_DISPATCHER_WATCHDOG_EN defined: a 3-bit counter SHALL run in WAIT_BUSY; if io_busy is not seen within 4 cycles, the FSM goes to RESPOND with rsp_error = 1 and rsp_data = 0.
REQ-027 Macro undefined: no watchdog logic; WAIT_BUSY waits indefinitely and rsp_error is tied 0.

Structure
REQ-028 Shared package io_ctrl_pkg SHALL hold the opcode constants (OP_MAINTAIN=000 … OP_MULTI_WRITE_DELAY=111), the FSM state encoding and the default widths.
REQ-029 The FIFO SHALL be a sub-module, io_cmd_fifo; the FSM and holding registers stay in io_dispatcher.

Verification
REQ-030 Write 000, reg 5, aux 3, with an io_busy model high for 4 cycles -> one io_valid_instruction pulse; rsp_valid after busy falls; rsp_data = 8'h00.
REQ-031 Read 100, reg 7, aux 0, model returns io_valid = 1 and io_result = 8'h01 on busy fall -> rsp_data = 8'h01 and latency exactly 4 cycles.
REQ-032 Push 5 commands back-to-back while io_busy is held high -> cmd_ready = 0 after the 4th; the 5th is accepted once the first pop occurs; 5 responses arrive in order.
REQ-033 Assert rst during WAIT_DONE with 2 commands buffered -> all outputs at reset values immediately; no rsp_valid afterwards.
REQ-034 With IO_DISPATCHER_WATCHDOG_EN defined and io_busy tied 0 -> rsp_valid with rsp_error = 1 four cycles after WAIT_BUSY entry; the next command proceeds normally.
REQ-035 Opcode 000 with io_valid = 1 asserted during issue -> rsp_data remains 8'h00.

Source files
------------

// File: rtl/io_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and default widths for the I/O dispatcher.
// Optional watchdog feature is enabled by defining IO_DISPATCHER_WATCHDOG_EN.
package io_ctrl_pkg;

  localparam int DEF_INSTRUCTION_SIZE = 3;
  localparam int DEF_REGISTER_SIZE    = 5;
  localparam int DEF_AUXILIAR_SIZE    = 44;
  localparam int DEF_IO_OUTPUT_SIZE   = 8;
  localparam int DEF_FIFO_DEPTH       = 4;

  localparam logic [2:0] OP_MAINTAIN          = 3'b000;
  localparam logic [2:0] OP_WRITE             = 3'b001;
  localparam logic [2:0] OP_WRITE_DELAY       = 3'b010;
  localparam logic [2:0] OP_MULTI_WRITE       = 3'b011;
  localparam logic [2:0] OP_READ              = 3'b100;
  localparam logic [2:0] OP_READ_DELAY        = 3'b101;
  localparam logic [2:0] OP_READ_WAIT         = 3'b110;
  localparam logic [2:0] OP_MULTI_WRITE_DELAY = 3'b111;

  // Cycles spent in WAIT_BUSY before the watchdog gives up on io_busy.
  localparam int WATCHDOG_LIMIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESPOND   = 3'd4
  } state_t;

endpackage

// File: rtl/io_cmd_fifo.sv
// Command buffer for the I/O dispatcher: power-of-two depth, wrapping pointers,
// occupancy count one bit wider than the pointers. Pushes into a full buffer are refused.
module io_cmd_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array is deliberately left without reset; an entry is only ever
  // read after it has been written, and the count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_dispatcher.sv
// Buffers host commands and issues them one at a time to an I/O execution unit,
// returning one response per command. Define IO_DISPATCHER_WATCHDOG_EN to time out a missing io_busy.
module io_dispatcher
  import io_ctrl_pkg::*;
#(
  parameter int INSTRUCTION_SIZE = DEF_INSTRUCTION_SIZE,
  parameter int REGISTER_SIZE    = DEF_REGISTER_SIZE,
  parameter int AUXILIAR_SIZE    = DEF_AUXILIAR_SIZE,
  parameter int IO_OUTPUT_SIZE   = DEF_IO_OUTPUT_SIZE,
  parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [INSTRUCTION_SIZE-1:0] cmd_instruction,
  input  logic [REGISTER_SIZE-1:0]    cmd_register,
  input  logic [AUXILIAR_SIZE-1:0]    cmd_auxiliar,
  output logic                        rsp_valid,
  output logic [IO_OUTPUT_SIZE-1:0]   rsp_data,
  output logic                        rsp_error,
  output logic [INSTRUCTION_SIZE-1:0] io_instruction,
  output logic [REGISTER_SIZE-1:0]    io_register,
  output logic [AUXILIAR_SIZE-1:0]    io_auxiliar,
  output logic                        io_valid_instruction,
  input  logic                        io_busy,
  input  logic                        io_valid,
  input  logic [IO_OUTPUT_SIZE-1:0]   io_result
);

  localparam int CMD_W = INSTRUCTION_SIZE + REGISTER_SIZE + AUXILIAR_SIZE;

  state_t                      state;
  logic [INSTRUCTION_SIZE-1:0] hold_instruction;
  logic [REGISTER_SIZE-1:0]    hold_register;
  logic [AUXILIAR_SIZE-1:0]    hold_auxiliar;
  logic [CMD_W-1:0]            fifo_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        fifo_pop;
  logic                        is_read;

  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !io_busy;

  // Only the read family returns data; io_valid is ignored for every other opcode.
  assign is_read = (hold_instruction == INSTRUCTION_SIZE'(OP_READ))       ||
                   (hold_instruction == INSTRUCTION_SIZE'(OP_READ_DELAY)) ||
                   (hold_instruction == INSTRUCTION_SIZE'(OP_READ_WAIT));

  assign io_instruction = hold_instruction;
  assign io_register    = hold_register;
  assign io_auxiliar    = hold_auxiliar;

  io_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_instruction, cmd_register, cmd_auxiliar}),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef IO_DISPATCHER_WATCHDOG_EN
  logic [2:0] wd_count;
  logic       rsp_error_q;

  assign rsp_error = rsp_error_q;
`else
  assign rsp_error = 1'b0;
`endif

  // NOTE: every register in this block uses non-blocking assignment so that all
  // next-state decisions see the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= ST_IDLE;
      hold_instruction     <= '0;
      hold_register        <= '0;
      hold_auxiliar        <= '0;
      io_valid_instruction <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_data             <= '0;
`ifdef IO_DISPATCHER_WATCHDOG_EN
      wd_count             <= '0;
      rsp_error_q          <= 1'b0;
`endif
    end else begin
      io_valid_instruction <= 1'b0;
      rsp_valid            <= 1'b0;
`ifdef IO_DISPATCHER_WATCHDOG_EN
      rsp_error_q          <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            {hold_instruction, hold_register, hold_auxiliar} <= fifo_data;
            io_valid_instruction <= 1'b1;
            state                <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_WAIT_BUSY;
`ifdef IO_DISPATCHER_WATCHDOG_EN
          wd_count <= '0;
`endif
        end
        ST_WAIT_BUSY: begin
          if (io_busy) begin
            state <= ST_WAIT_DONE;
`ifdef IO_DISPATCHER_WATCHDOG_EN
          end else if (wd_count == 3'(WATCHDOG_LIMIT - 1)) begin
            state       <= ST_RESPOND;
            rsp_valid   <= 1'b1;
            rsp_data    <= '0;
            rsp_error_q <= 1'b1;
          end else begin
            wd_count <= wd_count + 3'd1;
`endif
          end
        end
        ST_WAIT_DONE: begin
          if (!io_busy) begin
            state     <= ST_RESPOND;
            rsp_valid <= 1'b1;
            rsp_data  <= (is_read && io_valid) ? io_result : '0;
          end
        end
        ST_RESPOND: state <= ST_IDLE;
        default:    state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_dispatcher.sv
// Directed self-checking bench for io_dispatcher with a hand-driven execution-unit model.
// The watchdog steps run only when IO_DISPATCHER_WATCHDOG_EN is defined.
module tb_io_dispatcher;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_instruction;
  logic [4:0]  cmd_register;
  logic [43:0] cmd_auxiliar;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic [2:0]  io_instruction;
  logic [4:0]  io_register;
  logic [43:0] io_auxiliar;
  logic        io_valid_instruction;
  logic        io_busy;
  logic        io_valid;
  logic [7:0]  io_result;

  int checks = 0;
  int errors = 0;

  io_dispatcher dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_valid            (cmd_valid),
    .cmd_ready            (cmd_ready),
    .cmd_instruction      (cmd_instruction),
    .cmd_register         (cmd_register),
    .cmd_auxiliar         (cmd_auxiliar),
    .rsp_valid            (rsp_valid),
    .rsp_data             (rsp_data),
    .rsp_error            (rsp_error),
    .io_instruction       (io_instruction),
    .io_register          (io_register),
    .io_auxiliar          (io_auxiliar),
    .io_valid_instruction (io_valid_instruction),
    .io_busy              (io_busy),
    .io_valid             (io_valid),
    .io_result            (io_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
    check({tag, "_rsp_error"}, 64'(rsp_error), 64'(0));
    check({tag, "_io_vi"}, 64'(io_valid_instruction), 64'(0));
    check({tag, "_io_instr"}, 64'(io_instruction), 64'(0));
    check({tag, "_io_reg"}, 64'(io_register), 64'(0));
    check({tag, "_io_aux"}, 64'(io_auxiliar), 64'(0));
  endtask

  task automatic send(input logic [2:0] instr, input logic [4:0] rg, input logic [43:0] aux);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_instruction = instr;
    cmd_register = rg;
    cmd_auxiliar = aux;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("send_ready_timeout", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
  endtask

  // Waits for the issue pulse, then plays the execution unit: busy during WAIT_BUSY
  // for busy_n cycles, result presented from the issue cycle until the response.
  task automatic serve(input string tag, input logic [4:0] exp_reg, input int busy_n,
                       input logic vld, input logic [7:0] res, input logic [7:0] exp_data);
    int n;
    n = 0;
    while (io_valid_instruction !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_issue"}, 64'(io_valid_instruction), 64'(1));
    check({tag, "_reg"}, 64'(io_register), 64'(exp_reg));
    io_valid = vld;
    io_result = res;
    tick();
    io_busy = 1'b1;
    repeat (busy_n) tick();
    check({tag, "_hold_reg"}, 64'(io_register), 64'(exp_reg));
    check({tag, "_single_pulse"}, 64'(io_valid_instruction), 64'(0));
    check({tag, "_early_rsp"}, 64'(rsp_valid), 64'(0));
    io_busy = 1'b0;
    tick();
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_data));
    check({tag, "_rsp_error"}, 64'(rsp_error), 64'(0));
    io_valid = 1'b0;
    io_result = 8'h00;
    tick();
    check({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_instruction = '0;
    cmd_register = '0;
    cmd_auxiliar = '0;
    io_busy = 1'b0;
    io_valid = 1'b0;
    io_result = '0;
    repeat (2) tick();
    check_reset("rst");
    rst = 1'b0;
    tick();

    // Maintain opcode, busy high for four cycles.
    send(3'b000, 5'd5, 44'd3);
    serve("maintain", 5'd5, 4, 1'b0, 8'h00, 8'h00);
    check("maintain_aux", 64'(io_auxiliar), 64'(3));
    check("maintain_instr", 64'(io_instruction), 64'(0));

    // Read with one-cycle busy: response on the fourth cycle counting from issue.
    send(3'b100, 5'd7, 44'd0);
    serve("read_lat", 5'd7, 1, 1'b1, 8'h01, 8'h01);

    // Maintain with io_valid asserted from issue: data must clear to zero.
    send(3'b000, 5'd2, 44'd9);
    serve("maint_valid", 5'd2, 2, 1'b1, 8'hA5, 8'h00);

    send(3'b101, 5'd1, 44'd0);
    serve("read_dly", 5'd1, 1, 1'b1, 8'h3C, 8'h3C);
    send(3'b110, 5'd6, 44'd0);
    serve("read_novalid", 5'd6, 1, 1'b0, 8'h77, 8'h00);
    send(3'b110, 5'd6, 44'd0);
    serve("read_wait", 5'd6, 3, 1'b1, 8'h5A, 8'h5A);
    send(3'b011, 5'd4, 44'd1);
    serve("multi_write", 5'd4, 1, 1'b1, 8'hFF, 8'h00);

    // Fill the buffer while the unit reports busy.
    io_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1;
      cmd_instruction = 3'b100;
      cmd_register = 5'(10 + i);
      cmd_auxiliar = 44'(i);
      check("fill_ready", 64'(cmd_ready), 64'(1));
      tick();
    end
    check("full_not_ready", 64'(cmd_ready), 64'(0));
    cmd_register = 5'd14;
    cmd_auxiliar = 44'd4;
    tick();
    check("full_hold", 64'(cmd_ready), 64'(0));
    check("no_pop_busy", 64'(io_valid_instruction), 64'(0));
    io_busy = 1'b0;
    tick();
    check("first_pop_issue", 64'(io_valid_instruction), 64'(1));
    check("first_pop_reg", 64'(io_register), 64'(10));
    check("first_pop_ready", 64'(cmd_ready), 64'(1));
    tick();
    cmd_valid = 1'b0;
    check("fifth_accepted", 64'(cmd_ready), 64'(0));
    io_busy = 1'b1;
    io_valid = 1'b1;
    io_result = 8'h10;
    tick();
    io_busy = 1'b0;
    tick();
    check("order0_rsp", 64'(rsp_valid), 64'(1));
    check("order0_data", 64'(rsp_data), 64'(8'h10));
    io_valid = 1'b0;
    tick();
    for (int i = 1; i < 5; i++) begin
      serve($sformatf("order%0d", i), 5'(10 + i), 1, 1'b1, 8'(8'h10 + i), 8'(8'h10 + i));
    end

    // Reset during WAIT_DONE with two commands still buffered.
    send(3'b001, 5'd20, 44'd0);
    send(3'b001, 5'd21, 44'd0);
    send(3'b001, 5'd22, 44'd0);
    check("inflight_reg", 64'(io_register), 64'(20));
    io_busy = 1'b1;
    tick();
    check("inflight_hold", 64'(io_register), 64'(20));
    rst = 1'b1;
    #1;
    check_reset("midrst");
    io_busy = 1'b0;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid === 1'b1 || io_valid_instruction === 1'b1) seen++;
    end
    check("discarded_activity", 64'(seen), 64'(0));
    check("discarded_ready", 64'(cmd_ready), 64'(1));

    send(3'b110, 5'd3, 44'd0);
    serve("recover", 5'd3, 1, 1'b1, 8'h7E, 8'h7E);

`ifdef IO_DISPATCHER_WATCHDOG_EN
    send(3'b001, 5'd8, 44'd1);
    n = 0;
    while (io_valid_instruction !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("wd_issue", 64'(io_valid_instruction), 64'(1));
    n = 0;
    while (rsp_valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    // One cycle of ISSUE plus four in WAIT_BUSY.
    check("wd_latency", 64'(n), 64'(5));
    check("wd_error", 64'(rsp_error), 64'(1));
    check("wd_data", 64'(rsp_data), 64'(0));
    tick();
    check("wd_error_pulse", 64'(rsp_error), 64'(0));
    send(3'b100, 5'd9, 44'd0);
    serve("after_wd", 5'd9, 1, 1'b1, 8'h42, 8'h42);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
